// File: rtl/noc_params.sv
// Shared router parameters and the packet type carried across every link.
package noc_params;

    // Default input-buffer depth; must be a power of two >= 2.
    localparam int unsigned FIFO_DEPTH = 4;

    typedef struct packed {
        logic [1:0] dest;
        logic [7:0] payload;
    } packet_t;

    localparam int unsigned PKT_W = $bits(packet_t);

endpackage

// File: rtl/noc_input_fifo.sv
// Per-port first-word-fall-through input buffer. Presents the head packet and
// an empty flag to the arbiter, and returns a registered credit per pop.
module noc_input_fifo
    import noc_params::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [PKT_W-1:0]           wr_data,
    output logic                       full,
    input  logic                       rd_en,
    output logic [PKT_W-1:0]           rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       credit_out,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

    logic [PKT_W-1:0] mem [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            credit_q;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;

    logic push;
    logic pop;

    // Flags come only from registered occupancy.
    always_comb begin
        full  = (count_q == FullCount);
        empty = (count_q == '0);
    end

    // Accept decisions; a pop frees the slot a full-time push lands in.
    always_comb begin
        push = wr_en && (!full || rd_en);
        pop  = rd_en && !empty;
    end

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (wr_en && !push) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            credit_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            credit_q    <= pop;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array, deliberately not reset; emptiness masks stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Head-of-queue view; zero when empty to match the arbiter's idle packet.
    always_comb begin
        rd_data    = empty ? '0 : mem[rd_ptr_q];
        count      = count_q;
        credit_out = credit_q;
        overflow   = overflow_q;
        underflow  = underflow_q;
    end

endmodule

// File: tb/tb_noc_input_fifo.sv
// Directed bench for noc_input_fifo with hand-computed expectations.
module tb_noc_input_fifo;
    import noc_params::*;

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [PKT_W-1:0] wr_data;
    logic             full;
    logic             rd_en;
    logic [PKT_W-1:0] rd_data;
    logic             empty;
    logic [2:0]       count;
    logic             credit_out;
    logic             overflow;
    logic             underflow;

    int tests_run;
    int tests_failed;
    int credits;

    noc_input_fifo #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .count      (count),
        .credit_out (credit_out),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_only(input logic [PKT_W-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        rd_en   = 1'b0;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic pop_only();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    localparam logic [PKT_W-1:0] PktA = 10'h1A5;
    localparam logic [PKT_W-1:0] PktE = 10'h2EE;

    logic [PKT_W-1:0] p [4];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        p[0] = 10'h011;
        p[1] = 10'h122;
        p[2] = 10'h233;
        p[3] = 10'h344;

        #12;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_credit", 32'(credit_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
        rst_n = 1'b1;

        // Single push then pop.
        push_only(PktA);
        check("p1_empty", 32'(empty), 32'd0);
        check("p1_data", 32'(rd_data), 32'(PktA));
        check("p1_count", 32'(count), 32'd1);
        check("p1_credit", 32'(credit_out), 32'd0);
        pop_only();
        check("pop1_empty", 32'(empty), 32'd1);
        check("pop1_data", 32'(rd_data), 32'd0);
        check("pop1_credit", 32'(credit_out), 32'd1);
        step();
        check("pop1_credit_end", 32'(credit_out), 32'd0);

        // Fill, overflow, drain in order.
        for (int i = 0; i < 4; i++) push_only(p[i]);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd4);
        push_only(PktE);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_head", 32'(rd_data), 32'(p[0]));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_%0d", i), 32'(rd_data), 32'(p[i]));
            pop_only();
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_unf", 32'(underflow), 32'd0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 4; i++) push_only(p[i]);
        wr_en   = 1'b1;
        wr_data = PktE;
        rd_en   = 1'b1;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("fpp_count", 32'(count), 32'd4);
        check("fpp_head", 32'(rd_data), 32'(p[1]));
        check("fpp_credit", 32'(credit_out), 32'd1);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("fpp_out_%0d", i), 32'(rd_data), 32'(p[i]));
            pop_only();
        end
        check("fpp_out_e", 32'(rd_data), 32'(PktE));
        pop_only();
        check("fpp_empty", 32'(empty), 32'd1);
        step();

        // Empty with simultaneous push and pop: no bypass.
        wr_en   = 1'b1;
        wr_data = PktA;
        rd_en   = 1'b1;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("epp_count", 32'(count), 32'd1);
        check("epp_data", 32'(rd_data), 32'(PktA));
        check("epp_unf", 32'(underflow), 32'd1);
        check("epp_credit", 32'(credit_out), 32'd0);
        pop_only();
        check("epp_pop_credit", 32'(credit_out), 32'd1);
        step();

        // Streaming through pointer wrap.
        credits = 0;
        push_only(10'h100);
        for (int i = 1; i < 10; i++) begin
            wr_en   = 1'b1;
            wr_data = 10'(10'h100 + i);
            rd_en   = 1'b1;
            step();
            if (credit_out) credits++;
            check($sformatf("strm_data_%0d", i), 32'(rd_data), 32'(10'h100 + i));
            check($sformatf("strm_count_%0d", i), 32'(count), 32'd1);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("strm_credits", 32'(credits), 32'd9);
        pop_only();
        check("strm_last_credit", 32'(credit_out), 32'd1);
        check("strm_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-operation.
        for (int i = 0; i < 3; i++) push_only(p[i]);
        check("ar_count_pre", 32'(count), 32'd3);
        check("ar_ovf_pre", 32'(overflow), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_count", 32'(count), 32'd0);
        check("ar_empty", 32'(empty), 32'd1);
        check("ar_full", 32'(full), 32'd0);
        check("ar_data", 32'(rd_data), 32'd0);
        check("ar_credit", 32'(credit_out), 32'd0);
        check("ar_ovf", 32'(overflow), 32'd0);
        check("ar_unf", 32'(underflow), 32'd0);
        #2 rst_n = 1'b1;
        push_only(PktE);
        check("ar_post_data", 32'(rd_data), 32'(PktE));
        check("ar_post_count", 32'(count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
